// File: rtl/stack_unit.sv
// Hardware stack controller: NUM_STACKS pointers behind a register block plus a push/pop/top window
// that drives the stack RAM. Optional overflow/underflow guard is enabled by defining STACK_GUARD_EN.
module stack_unit #(
  parameter int          NUM_STACKS = 2,
  parameter int          PTR_WIDTH  = 12,
  parameter logic [15:0] REG_BASE   = 16'hFC00,
  parameter logic [15:0] WIN_BASE   = 16'hC000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          addr,
  input  logic [7:0]           wdata,
  input  logic                 we,
  input  logic                 re,
  output logic [7:0]           rdata,
  output logic                 rdata_oe,
  output logic [PTR_WIDTH-1:0] bank_addr,
  output logic                 n_bank_ce,
  output logic                 irq
);

  localparam logic [PTR_WIDTH-1:0] SP_ONES = '1;
  localparam logic [PTR_WIDTH-1:0] SP_ONE  = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

  logic [PTR_WIDTH-1:0]  sp [NUM_STACKS];
  logic [NUM_STACKS-1:0] en;
  logic [NUM_STACKS-1:0] ovf;
  logic [NUM_STACKS-1:0] udf;

  // Address decode; offsets below the base wrap to large values and miss the hit compare.
  logic [15:0] reg_off;
  logic [15:0] win_off;
  logic        reg_hit;
  logic        win_hit;
  logic [2:0]  reg_ch;
  logic [2:0]  win_ch;
  logic [1:0]  reg_sel;
  logic        win_port;

  assign reg_off  = addr - REG_BASE;
  assign win_off  = addr - WIN_BASE;
  assign reg_hit  = (reg_off < 16'(4 * NUM_STACKS));
  assign win_hit  = (win_off < 16'(2 * NUM_STACKS));
  assign reg_ch   = reg_off[4:2];
  assign reg_sel  = reg_off[1:0];
  assign win_ch   = win_off[3:1];
  assign win_port = win_off[0];

  // Per-channel state of the channel addressed by each decoder.
  logic [PTR_WIDTH-1:0] win_sp;
  logic                 win_en;
  logic [PTR_WIDTH-1:0] reg_sp;
  logic                 reg_en;
  logic                 reg_ovf;
  logic                 reg_udf;

  always_comb begin
    win_sp  = sp[0];
    win_en  = 1'b0;
    reg_sp  = '0;
    reg_en  = 1'b0;
    reg_ovf = 1'b0;
    reg_udf = 1'b0;
    for (int k = 0; k < NUM_STACKS; k++) begin
      if (win_ch == 3'(k)) begin
        win_sp = sp[k];
        win_en = en[k];
      end
      if (reg_ch == 3'(k)) begin
        reg_sp  = sp[k];
        reg_en  = en[k];
        reg_ovf = ovf[k];
        reg_udf = udf[k];
      end
    end
  end

  // A simultaneous we/re is a write, so a pop only happens on a pure read.
  logic push_req;
  logic pop_req;
  logic any_req;
  logic ovf_hit;
  logic udf_hit;
  logic bank_go;

  assign push_req = win_hit & win_port & we;
  assign pop_req  = win_hit & win_port & re & ~we;
  assign any_req  = win_hit & (we | re);

`ifdef STACK_GUARD_EN
  assign ovf_hit = push_req & win_en & (win_sp == '0);
  assign udf_hit = pop_req & win_en & (win_sp == SP_ONES);
  assign irq     = |(en & (ovf | udf));
`else
  assign ovf_hit = 1'b0;
  assign udf_hit = 1'b0;
  assign irq     = 1'b0;
`endif

  assign bank_go = any_req & win_en & ~ovf_hit & ~udf_hit;

  // rst also forces outputs directly so an access in flight is dropped without a clock edge.
  always_comb begin
    if (rst)          bank_addr = SP_ONES;
    else if (pop_req) bank_addr = win_sp + SP_ONE;
    else if (win_hit) bank_addr = win_sp;
    else              bank_addr = sp[0];
  end

  assign n_bank_ce = rst | ~bank_go;
  assign rdata_oe  = ~rst & re & reg_hit;

  logic [15:0] sp_ext;
  assign sp_ext = 16'(reg_sp);

  always_comb begin
    rdata = 8'h00;
    if (rdata_oe) begin
      case (reg_sel)
        2'd0:    rdata = sp_ext[7:0];
        2'd1:    rdata = sp_ext[15:8];
        2'd3:    rdata = {5'b0, reg_udf, reg_ovf, reg_en};
        default: rdata = 8'h00;
      endcase
    end
  end

  // Next pointer values for register writes; high-byte bits beyond PTR_WIDTH are dropped.
  logic [PTR_WIDTH-1:0] sp_lo_val;
  logic [PTR_WIDTH-1:0] sp_hi_val;
  logic [PTR_WIDTH-1:0] sp_cmd_val;

  always_comb begin
    sp_lo_val      = reg_sp;
    sp_lo_val[7:0] = wdata;
    sp_hi_val      = reg_sp;
    for (int b = 8; b < PTR_WIDTH; b++) begin
      sp_hi_val[b] = wdata[b-8];
    end
    if (wdata[2])                  sp_cmd_val = SP_ONES;
    else if (wdata[0] & ~wdata[1]) sp_cmd_val = reg_sp + SP_ONE;
    else if (wdata[1] & ~wdata[0]) sp_cmd_val = reg_sp - SP_ONE;
    else                           sp_cmd_val = reg_sp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_STACKS; k++) begin
        sp[k] <= SP_ONES;
      end
      en  <= '0;
      ovf <= '0;
      udf <= '0;
    end else begin
      for (int k = 0; k < NUM_STACKS; k++) begin
        if (reg_hit && we && (reg_ch == 3'(k))) begin
          case (reg_sel)
            2'd0: sp[k] <= sp_lo_val;
            2'd1: sp[k] <= sp_hi_val;
            2'd2: sp[k] <= sp_cmd_val;
            default: begin
              en[k] <= wdata[0];
              if (wdata[1]) ovf[k] <= 1'b0;
              if (wdata[2]) udf[k] <= 1'b0;
            end
          endcase
        end
        // Empty-descending stack: push stores at sp then decrements, pop reads sp+1 then increments.
        if (win_hit && (win_ch == 3'(k))) begin
          if (bank_go && push_req) sp[k] <= win_sp - SP_ONE;
          if (bank_go && pop_req)  sp[k] <= win_sp + SP_ONE;
          if (ovf_hit)             ovf[k] <= 1'b1;
          if (udf_hit)             udf[k] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit (NUM_STACKS=2, PTR_WIDTH=12); expectations follow STACK_GUARD_EN.
module tb_stack_unit;

  localparam int NS = 2;
  localparam int PW = 12;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic [15:0]   addr  = 16'h0000;
  logic [7:0]    wdata = 8'h00;
  logic          we    = 1'b0;
  logic          re    = 1'b0;
  logic [7:0]    rdata;
  logic          rdata_oe;
  logic [PW-1:0] bank_addr;
  logic          n_bank_ce;
  logic          irq;

  stack_unit #(
    .NUM_STACKS(NS),
    .PTR_WIDTH (PW),
    .REG_BASE  (16'hFC00),
    .WIN_BASE  (16'hC000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .rdata_oe (rdata_oe),
    .bank_addr(bank_addr),
    .n_bank_ce(n_bank_ce),
    .irq      (irq)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [PW-1:0] m_sp [NS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_compare(input string tag, input logic [15:0] got);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, 32'(got), 32'(e));
    end
  endtask

  // Driver: inputs change on the falling edge, outputs are sampled 2 time units later.
  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = w;
    re    = r;
    #2;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
    drive(a, d, 1'b1, 1'b0);
    finish_cycle();
  endtask

  task automatic reg_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    exp_q.push_back({7'b0, 1'b1, exp});
    drive(a, 8'h00, 1'b0, 1'b1);
    sb_compare(tag, {7'b0, rdata_oe, rdata});
    finish_cycle();
  endtask

  task automatic win_access(input string tag, input logic [15:0] a, input logic w, input logic r,
                            input logic [PW-1:0] exp_bank, input logic exp_ce);
    exp_q.push_back(16'({exp_ce, exp_bank}));
    drive(a, 8'h5A, w, r);
    sb_compare(tag, 16'({n_bank_ce, bank_addr}));
    finish_cycle();
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    // Reset state
    #2;
    check_eq("rst_ce", 32'(n_bank_ce), 32'd1);
    check_eq("rst_oe", 32'(rdata_oe), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_bank", 32'(bank_addr), 32'hFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    reg_read("rst_sp0_lo", 16'hFC00, 8'hFF);
    reg_read("rst_sp0_hi", 16'hFC01, 8'h0F);
    reg_read("rst_stat0", 16'hFC03, 8'h00);
    reg_read("rst_stat1", 16'hFC07, 8'h00);

    // Disabled channel: no RAM access, pointer untouched
    win_access("dis_push", 16'hC001, 1'b1, 1'b0, 12'hFFF, 1'b1);
    reg_read("dis_sp", 16'hFC00, 8'hFF);

    // Enable ch0, back-to-back pushes, then pop and top access
    reg_write(16'hFC03, 8'h01);
    reg_read("en0_stat", 16'hFC03, 8'h01);
    win_access("push1", 16'hC001, 1'b1, 1'b0, 12'hFFF, 1'b0);
    win_access("push2", 16'hC001, 1'b1, 1'b0, 12'hFFE, 1'b0);
    win_access("push3", 16'hC001, 1'b1, 1'b0, 12'hFFD, 1'b0);
    reg_read("push_sp_lo", 16'hFC00, 8'hFC);
    reg_read("push_sp_hi", 16'hFC01, 8'h0F);
    win_access("pop1", 16'hC001, 1'b0, 1'b1, 12'hFFD, 1'b0);
    reg_read("pop_sp_lo", 16'hFC00, 8'hFD);
    win_access("top_rd", 16'hC000, 1'b0, 1'b1, 12'hFFD, 1'b0);
    win_access("top_wr", 16'hC000, 1'b1, 1'b0, 12'hFFD, 1'b0);
    reg_read("top_sp_lo", 16'hFC00, 8'hFD);

    // CMD register on ch1
    reg_write(16'hFC07, 8'h01);
    reg_write(16'hFC06, 8'h01);
    reg_read("cmd_inc_lo", 16'hFC04, 8'h00);
    reg_read("cmd_inc_hi", 16'hFC05, 8'h00);
    reg_write(16'hFC06, 8'h02);
    reg_read("cmd_dec_lo", 16'hFC04, 8'hFF);
    reg_read("cmd_dec_hi", 16'hFC05, 8'h0F);
    reg_write(16'hFC06, 8'h03);
    reg_read("cmd_both", 16'hFC04, 8'hFF);
    reg_write(16'hFC06, 8'h02);
    reg_read("cmd_dec2", 16'hFC04, 8'hFE);
    reg_write(16'hFC06, 8'h04);
    reg_read("cmd_reload_lo", 16'hFC04, 8'hFF);
    reg_read("cmd_reload_hi", 16'hFC05, 8'h0F);
    reg_read("cmd_ch0_kept", 16'hFC00, 8'hFD);

    // Direct SP write, high bits above PTR_WIDTH ignored; push on ch1
    reg_write(16'hFC04, 8'h34);
    reg_write(16'hFC05, 8'hA2);
    reg_read("spw_hi", 16'hFC05, 8'h02);
    reg_read("spw_lo", 16'hFC04, 8'h34);
    win_access("ch1_push", 16'hC003, 1'b1, 1'b0, 12'h234, 1'b0);
    reg_read("ch1_push_sp", 16'hFC04, 8'h33);

    // we and re together behave as a push
    win_access("we_re", 16'hC001, 1'b1, 1'b1, 12'hFFD, 1'b0);
    reg_read("we_re_sp", 16'hFC00, 8'hFC);

    // Addresses of a nonexistent channel miss both decoders
    win_access("nohit_win", 16'hC004, 1'b1, 1'b0, 12'hFFC, 1'b1);
    drive(16'hFC08, 8'h00, 1'b0, 1'b1);
    check_eq("nohit_reg", 32'({rdata_oe, rdata}), 32'd0);
    finish_cycle();

    // Boundary push at sp=0 and pop at sp=all-ones
    reg_write(16'hFC00, 8'h00);
    reg_write(16'hFC01, 8'h00);
`ifdef STACK_GUARD_EN
    win_access("ovf_push", 16'hC001, 1'b1, 1'b0, 12'h000, 1'b1);
    reg_read("ovf_stat", 16'hFC03, 8'h03);
    check_eq("ovf_irq", 32'(irq), 32'd1);
    reg_read("ovf_sp", 16'hFC00, 8'h00);
    reg_write(16'hFC03, 8'h03);
    reg_read("ovf_clr", 16'hFC03, 8'h01);
    check_eq("ovf_clr_irq", 32'(irq), 32'd0);
    reg_write(16'hFC02, 8'h04);
    win_access("udf_pop", 16'hC001, 1'b0, 1'b1, 12'h000, 1'b1);
    reg_read("udf_stat", 16'hFC03, 8'h05);
    check_eq("udf_irq", 32'(irq), 32'd1);
    reg_read("udf_sp", 16'hFC00, 8'hFF);
    reg_write(16'hFC03, 8'h05);
    check_eq("udf_clr_irq", 32'(irq), 32'd0);
`else
    win_access("wrap_push", 16'hC001, 1'b1, 1'b0, 12'h000, 1'b0);
    reg_read("wrap_push_lo", 16'hFC00, 8'hFF);
    reg_read("wrap_push_hi", 16'hFC01, 8'h0F);
    reg_read("wrap_stat", 16'hFC03, 8'h01);
    check_eq("wrap_irq", 32'(irq), 32'd0);
    win_access("wrap_pop", 16'hC001, 1'b0, 1'b1, 12'h000, 1'b0);
    reg_read("wrap_pop_lo", 16'hFC00, 8'h00);
    reg_read("wrap_pop_hi", 16'hFC01, 8'h00);
`endif

    // Random push/pop mix on both channels from a mid-range pointer
    for (int ch = 0; ch < NS; ch++) begin
      reg_write(16'hFC00 + 16'(4 * ch), 8'h00);
      reg_write(16'hFC01 + 16'(4 * ch), 8'h08);
      m_sp[ch] = 12'h800;
    end
    for (int i = 0; i < 40; i++) begin
      int ch;
      ch = int'($urandom_range(0, NS - 1));
      if ($urandom_range(0, 1) == 1) begin
        win_access("rnd_push", 16'hC001 + 16'(2 * ch), 1'b1, 1'b0, m_sp[ch], 1'b0);
        m_sp[ch] = m_sp[ch] - 12'd1;
      end else begin
        win_access("rnd_pop", 16'hC001 + 16'(2 * ch), 1'b0, 1'b1, m_sp[ch] + 12'd1, 1'b0);
        m_sp[ch] = m_sp[ch] + 12'd1;
      end
    end
    for (int ch = 0; ch < NS; ch++) begin
      reg_read("rnd_sp_lo", 16'hFC00 + 16'(4 * ch), m_sp[ch][7:0]);
      reg_read("rnd_sp_hi", 16'hFC01 + 16'(4 * ch), {4'h0, m_sp[ch][11:8]});
    end

    // Reset in the middle of a push cycle
    drive(16'hC001, 8'h00, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("arst_ce", 32'(n_bank_ce), 32'd1);
    check_eq("arst_bank", 32'(bank_addr), 32'hFFF);
    check_eq("arst_oe", 32'(rdata_oe), 32'd0);
    check_eq("arst_irq", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    reg_read("arst_sp_lo", 16'hFC00, 8'hFF);
    reg_read("arst_sp_hi", 16'hFC01, 8'h0F);
    reg_read("arst_stat", 16'hFC03, 8'h00);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
